// File: rtl/stage_pkg.sv
// Shared types and constants for the collision stage sequencer.
// The state enum, the stage codes seen by the renderers and the default frame counts.
package stage_pkg;

    typedef enum logic [2:0] {
        S_START = 3'd0,
        S_ST1   = 3'd1,
        S_ST2   = 3'd2,
        S_ST3   = 3'd3,
        S_END   = 3'd4,
        S_COOL  = 3'd5,
        S_DONE  = 3'd6
    } stage_state_t;

    localparam logic [2:0] STG_START = 3'd0;
    localparam logic [2:0] STG_ST1   = 3'd1;
    localparam logic [2:0] STG_ST2   = 3'd2;
    localparam logic [2:0] STG_ST3   = 3'd3;
    localparam logic [2:0] STG_END   = 3'd4;
    localparam logic [2:0] STG_DONE  = 3'd5;

    localparam int DEF_PIX_THRESH      = 50;
    localparam int DEF_CONFIRM_FRAMES  = 3;
    localparam int DEF_COOLDOWN_FRAMES = 30;
    localparam int DEF_TIMEOUT_FRAMES  = 1800;

    // Stage code shown while sitting in a given state (S_COOL is handled by the caller).
    function automatic logic [2:0] state_code(stage_state_t s);
        case (s)
            S_START: return STG_START;
            S_ST1:   return STG_ST1;
            S_ST2:   return STG_ST2;
            S_ST3:   return STG_ST3;
            S_END:   return STG_END;
            S_DONE:  return STG_DONE;
            default: return STG_START;
        endcase
    endfunction

    // State to enter when a cooldown finishes with a given pending stage code.
    function automatic stage_state_t code_to_state(logic [2:0] c);
        case (c)
            STG_ST1: return S_ST1;
            STG_ST2: return S_ST2;
            STG_ST3: return S_ST3;
            STG_END: return S_END;
            default: return S_START;
        endcase
    endfunction

endpackage

// File: rtl/hit_qualifier.sv
// Frame-level qualification of a raw per-pixel collision flag.
// A frame is a hit when at least PIX_THRESH flagged pixels were seen; confirmed
// is raised combinationally in the frame_tick cycle that completes the run of
// CONFIRM_FRAMES consecutive hits.
module hit_qualifier
    import stage_pkg::*;
#(
    parameter int PIX_THRESH     = DEF_PIX_THRESH,
    parameter int CONFIRM_FRAMES = DEF_CONFIRM_FRAMES
) (
    input  logic clk_25MHz,
    input  logic reset,
    input  logic flag,
    input  logic frame_tick,
    input  logic clr,
    output logic confirmed
);

    localparam int PW = $clog2(PIX_THRESH + 1);
    localparam int HW = $clog2(CONFIRM_FRAMES + 1);

    logic [PW-1:0] pix_cnt;
    logic [HW-1:0] hit_cnt;
    logic          frame_hit;

    assign frame_hit = (pix_cnt == PW'(PIX_THRESH));
    assign confirmed = frame_tick && frame_hit && (hit_cnt >= HW'(CONFIRM_FRAMES - 1));

    // Saturating pixel count per frame and consecutive-hit run length; a flag
    // coincident with the tick seeds the next frame's count.
    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            pix_cnt <= '0;
            hit_cnt <= '0;
        end else if (clr) begin
            pix_cnt <= '0;
            hit_cnt <= '0;
        end else if (frame_tick) begin
            if (!frame_hit) begin
                hit_cnt <= '0;
            end else if (hit_cnt != HW'(CONFIRM_FRAMES)) begin
                hit_cnt <= hit_cnt + HW'(1);
            end
            pix_cnt <= PW'(flag);
        end else if (flag && !frame_hit) begin
            pix_cnt <= pix_cnt + PW'(1);
        end
    end

endmodule

// File: rtl/collision_stage_sequencer.sv
// Game-flow sequencer for the VGA collision detector: enables one target at a
// time, advances the stage on a confirmed hit and inserts a cooldown between stages.
// Optional STAGE_TIMEOUT_EN: stages 1-3 give up after TIMEOUT_FRAMES frames and
// fall back to START through a cooldown.
//
// state   | meaning
// S_START | start target enabled, waiting for confirmation
// S_ST1   | stage 1 target enabled
// S_ST2   | stage 2 target enabled
// S_ST3   | stage 3 target enabled
// S_END   | ending target enabled
// S_COOL  | all targets disabled, counting frames before next_stage
// S_DONE  | game finished, waiting for restart
module collision_stage_sequencer
    import stage_pkg::*;
#(
    parameter int PIX_THRESH      = DEF_PIX_THRESH,
    parameter int CONFIRM_FRAMES  = DEF_CONFIRM_FRAMES,
    parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
    parameter int TIMEOUT_FRAMES  = DEF_TIMEOUT_FRAMES
) (
    input  logic       clk_25MHz,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       restart,
    input  logic       collision_detected,
    input  logic       collision_detected1,
    input  logic       collision_detected2,
    input  logic       collision_detected3,
    input  logic       collision_detected_ending,
    output logic       collision_en_start,
    output logic       collision_en1,
    output logic       collision_en2,
    output logic       collision_en3,
    output logic       collision_en_ending,
    output logic [2:0] stage,
    output logic       stage_adv,
    output logic       game_done,
    output logic       timeout
);

    localparam int CW = $clog2(COOLDOWN_FRAMES + 1);

    stage_state_t  state_q, state_nxt;
    logic [2:0]    next_stage_q, next_stage_nxt;
    logic [2:0]    stage_q, stage_nxt;
    logic          stage_adv_q;
    logic [4:0]    en_q, en_nxt;
    logic [CW-1:0] cool_cnt_q;
    logic          flag_sel;
    logic          confirmed;
    logic          qual_clr;
    logic          to_fire;
    logic          timed_stage;

    assign timed_stage = (state_q == S_ST1) || (state_q == S_ST2) || (state_q == S_ST3);

    // Only the flag of the currently enabled target reaches the qualifier.
    assign flag_sel = |({collision_detected_ending, collision_detected3, collision_detected2,
                         collision_detected1, collision_detected} & en_q);

    // Counters restart on every state change and stay clear outside the playing states.
    assign qual_clr = (state_nxt != state_q) || (state_q == S_COOL) || (state_q == S_DONE);

    hit_qualifier #(
        .PIX_THRESH     (PIX_THRESH),
        .CONFIRM_FRAMES (CONFIRM_FRAMES)
    ) u_hit_qualifier (
        .clk_25MHz  (clk_25MHz),
        .reset      (reset),
        .flag       (flag_sel),
        .frame_tick (frame_tick),
        .clr        (qual_clr),
        .confirmed  (confirmed)
    );

`ifdef STAGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_FRAMES + 1);
    logic [TW-1:0] to_cnt_q;
    logic          timeout_q;

    assign to_fire = timed_stage && frame_tick && (to_cnt_q == TW'(1));
    assign timeout = timeout_q;

    // Frames remaining in the current timed stage; reloaded whenever not in one.
    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            to_cnt_q <= TW'(TIMEOUT_FRAMES);
        end else if (!timed_stage) begin
            to_cnt_q <= TW'(TIMEOUT_FRAMES);
        end else if (frame_tick && to_cnt_q != '0) begin
            to_cnt_q <= to_cnt_q - TW'(1);
        end
    end

    // Single-cycle timeout pulse; a confirmation in the same tick suppresses it.
    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= to_fire && !confirmed;
        end
    end
`else
    logic [31:0] unused_timeout_frames;
    assign unused_timeout_frames = TIMEOUT_FRAMES;
    assign to_fire = 1'b0;
    assign timeout = 1'b0;
`endif

    // Cooldown frames remaining; reloaded whenever not cooling down.
    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            cool_cnt_q <= CW'(COOLDOWN_FRAMES);
        end else if (state_q != S_COOL) begin
            cool_cnt_q <= CW'(COOLDOWN_FRAMES);
        end else if (frame_tick && cool_cnt_q != '0) begin
            cool_cnt_q <= cool_cnt_q - CW'(1);
        end
    end

    // Next state, pending stage, displayed stage code and target enables.
    always_comb begin
        state_nxt      = state_q;
        next_stage_nxt = next_stage_q;
        case (state_q)
            S_START, S_ST1, S_ST2, S_ST3: begin
                if (confirmed) begin
                    state_nxt      = S_COOL;
                    next_stage_nxt = state_code(state_q) + 3'd1;
                end else if (to_fire) begin
                    state_nxt      = S_COOL;
                    next_stage_nxt = STG_START;
                end
            end
            S_END: begin
                if (confirmed) begin
                    state_nxt = S_DONE;
                end
            end
            S_COOL: begin
                if (frame_tick && cool_cnt_q == CW'(1)) begin
                    state_nxt = code_to_state(next_stage_q);
                end
            end
            S_DONE: begin
                if (restart) begin
                    state_nxt = S_START;
                end
            end
            default: state_nxt = S_START;
        endcase

        // During cooldown the renderer already shows the upcoming scene.
        stage_nxt = (state_nxt == S_COOL) ? next_stage_nxt : state_code(state_nxt);

        en_nxt = 5'b00000;
        case (state_nxt)
            S_START: en_nxt = 5'b00001;
            S_ST1:   en_nxt = 5'b00010;
            S_ST2:   en_nxt = 5'b00100;
            S_ST3:   en_nxt = 5'b01000;
            S_END:   en_nxt = 5'b10000;
            default: en_nxt = 5'b00000;
        endcase
    end

    // State and registered outputs; stage_adv marks each change of the displayed stage.
    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            state_q      <= S_START;
            next_stage_q <= STG_START;
            stage_q      <= STG_START;
            stage_adv_q  <= 1'b0;
            en_q         <= 5'b00001;
        end else begin
            state_q      <= state_nxt;
            next_stage_q <= next_stage_nxt;
            stage_q      <= stage_nxt;
            stage_adv_q  <= (stage_nxt != stage_q);
            en_q         <= en_nxt;
        end
    end

    assign collision_en_start  = en_q[0];
    assign collision_en1       = en_q[1];
    assign collision_en2       = en_q[2];
    assign collision_en3       = en_q[3];
    assign collision_en_ending = en_q[4];
    assign stage               = stage_q;
    assign stage_adv           = stage_adv_q;
    assign game_done           = (state_q == S_DONE);

endmodule

// File: tb/tb_collision_stage_sequencer.sv
// Self-checking bench for collision_stage_sequencer: frame-level vector table,
// hand sequences for reset/timeout corners, and randomized frames checked every
// cycle against a frame-level game model.
module tb_collision_stage_sequencer;

    localparam int PIX  = 50;
    localparam int CONF = 3;
    localparam int COOL = 30;
    localparam int TO   = 10;
    localparam int FL   = 110;
`ifdef STAGE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk_25MHz = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       restart;
    logic [4:0] flags;
    logic       collision_en_start, collision_en1, collision_en2, collision_en3, collision_en_ending;
    logic [2:0] stage;
    logic       stage_adv, game_done, timeout;
    logic [4:0] en_act;

    int checks = 0;
    int errors = 0;

    collision_stage_sequencer #(
        .TIMEOUT_FRAMES (TO)
    ) dut (
        .clk_25MHz                 (clk_25MHz),
        .reset                     (reset),
        .frame_tick                (frame_tick),
        .restart                   (restart),
        .collision_detected        (flags[0]),
        .collision_detected1       (flags[1]),
        .collision_detected2       (flags[2]),
        .collision_detected3       (flags[3]),
        .collision_detected_ending (flags[4]),
        .collision_en_start        (collision_en_start),
        .collision_en1             (collision_en1),
        .collision_en2             (collision_en2),
        .collision_en3             (collision_en3),
        .collision_en_ending       (collision_en_ending),
        .stage                     (stage),
        .stage_adv                 (stage_adv),
        .game_done                 (game_done),
        .timeout                   (timeout)
    );

    assign en_act = {collision_en_ending, collision_en3, collision_en2, collision_en1, collision_en_start};

    always #20 clk_25MHz = ~clk_25MHz;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level game model ----------------
    int m_stage, m_cool_ticks, m_pix, m_run, m_frames, m_prev;
    bit m_cool, m_done, e_adv, e_timeout;
    bit s_reset, s_tick, s_restart;
    logic [4:0] s_flags;

    task automatic model_reset();
        m_stage = 0; m_cool = 0; m_done = 0; m_cool_ticks = 0;
        m_pix = 0; m_run = 0; m_frames = 0; e_adv = 0; e_timeout = 0;
    endtask

    task automatic model_leave_stage();
        m_pix = 0; m_run = 0; m_frames = 0;
    endtask

    task automatic model_step();
        m_prev = m_stage;
        e_timeout = 0;
        if (m_done) begin
            if (s_restart) begin
                m_done = 0; m_stage = 0; model_leave_stage();
            end
        end else if (m_cool) begin
            if (s_tick) begin
                m_cool_ticks++;
                if (m_cool_ticks == COOL) begin
                    m_cool = 0; model_leave_stage();
                end
            end
        end else if (s_tick) begin
            if (m_pix >= PIX) m_run = (m_run < CONF) ? m_run + 1 : CONF;
            else m_run = 0;
            m_pix = int'(s_flags[m_stage]);
            m_frames++;
            if (m_run >= CONF) begin
                if (m_stage == 4) begin
                    m_done = 1; m_stage = 5;
                end else begin
                    m_cool = 1; m_cool_ticks = 0; m_stage = m_stage + 1;
                end
                model_leave_stage();
            end else if (TO_EN && m_stage >= 1 && m_stage <= 3 && m_frames >= TO) begin
                m_cool = 1; m_cool_ticks = 0; m_stage = 0; e_timeout = 1;
                model_leave_stage();
            end
        end else begin
            m_pix += int'(s_flags[m_stage]);
        end
        e_adv = (m_stage != m_prev);
    endtask

    function automatic logic [15:0] model_vec();
        logic [4:0] e_en;
        e_en = (m_cool || m_done) ? 5'b00000 : (5'b00001 << m_stage);
        return 16'({e_en, 3'(m_stage), e_adv, m_done, e_timeout});
    endfunction

    // Sample inputs at the edge, then advance the model and compare 5 time units later.
    always begin
        @(posedge clk_25MHz);
        s_reset = reset; s_tick = frame_tick; s_restart = restart; s_flags = flags;
        #5;
        if (s_reset || reset) begin
            model_reset();
        end else begin
            model_step();
            check("cycle", 16'({en_act, stage, stage_adv, game_done, timeout}), model_vec());
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic run_frame(input int idx, input int npix, input int len);
        for (int c = 0; c < len; c++) begin
            @(negedge clk_25MHz);
            flags      = (c < npix) ? (5'b00001 << idx) : 5'b00000;
            frame_tick = (c == len - 1);
        end
        @(negedge clk_25MHz);
        flags      = 5'b00000;
        frame_tick = 1'b0;
    endtask

    task automatic idle_frames(input int n);
        for (int i = 0; i < n; i++) run_frame(0, 0, FL);
    endtask

    typedef struct {
        int         reps;
        int         idx;
        int         npix;
        bit         rst;
        logic [2:0] stg;
        logic       adv;
        logic [4:0] en;
        logic       done;
    } vec_t;

    vec_t tbl[$];

    initial begin
        reset = 1'b1; frame_tick = 1'b0; restart = 1'b0; flags = 5'b00000;
        #50;
        check("reset_vals", 16'({en_act, stage, stage_adv, game_done, timeout}), 16'({5'b00001, 3'd0, 3'b000}));
        @(negedge clk_25MHz);
        reset = 1'b0;

        //            reps idx npix rst stg  adv  en        done
        tbl.push_back('{5,  0, 0,   0, 3'd0, 1'b0, 5'b00001, 1'b0});
        tbl.push_back('{2,  0, 60,  0, 3'd0, 1'b0, 5'b00001, 1'b0});
        tbl.push_back('{1,  0, 60,  0, 3'd1, 1'b1, 5'b00000, 1'b0});
        tbl.push_back('{29, 0, 60,  0, 3'd1, 1'b0, 5'b00000, 1'b0});
        tbl.push_back('{1,  0, 0,   0, 3'd1, 1'b0, 5'b00010, 1'b0});
        tbl.push_back('{4,  2, 100, 0, 3'd1, 1'b0, 5'b00010, 1'b0});
        tbl.push_back('{1,  1, 60,  0, 3'd1, 1'b0, 5'b00010, 1'b0});
        tbl.push_back('{1,  1, 49,  0, 3'd1, 1'b0, 5'b00010, 1'b0});
        tbl.push_back('{2,  1, 60,  0, 3'd1, 1'b0, 5'b00010, 1'b0});
        tbl.push_back('{1,  1, 60,  0, 3'd2, 1'b1, 5'b00000, 1'b0});
        tbl.push_back('{30, 0, 0,   0, 3'd2, 1'b0, 5'b00100, 1'b0});
        tbl.push_back('{3,  2, 50,  0, 3'd3, 1'b1, 5'b00000, 1'b0});
        tbl.push_back('{30, 0, 0,   0, 3'd3, 1'b0, 5'b01000, 1'b0});
        tbl.push_back('{3,  3, 60,  0, 3'd4, 1'b1, 5'b00000, 1'b0});
        tbl.push_back('{30, 0, 0,   0, 3'd4, 1'b0, 5'b10000, 1'b0});
        tbl.push_back('{1,  0, 0,   1, 3'd4, 1'b0, 5'b10000, 1'b0});
        tbl.push_back('{3,  4, 60,  0, 3'd5, 1'b1, 5'b00000, 1'b1});
        tbl.push_back('{2,  4, 60,  0, 3'd5, 1'b0, 5'b00000, 1'b1});
        tbl.push_back('{1,  0, 0,   1, 3'd0, 1'b1, 5'b00001, 1'b0});
        tbl.push_back('{3,  0, 60,  0, 3'd1, 1'b1, 5'b00000, 1'b0});

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) begin
                @(negedge clk_25MHz);
                restart = 1'b1; frame_tick = 1'b1;
                @(negedge clk_25MHz);
                restart = 1'b0; frame_tick = 1'b0;
            end else begin
                for (int r = 0; r < tbl[i].reps; r++) run_frame(tbl[i].idx, tbl[i].npix, FL);
            end
            check($sformatf("vec%0d", i), 16'({en_act, stage, stage_adv, game_done}),
                  16'({tbl[i].en, tbl[i].stg, tbl[i].adv, tbl[i].done}));
        end

        // Reset asserted asynchronously in the middle of a cooldown.
        idle_frames(5);
        check("cool_mid", 16'({en_act, stage}), 16'({5'b00000, 3'd1}));
        @(negedge clk_25MHz);
        #5 reset = 1'b1;
        #1 check("reset_mid_cool", 16'({en_act, stage, stage_adv, game_done, timeout}),
                 16'({5'b00001, 3'd0, 3'b000}));
        @(negedge clk_25MHz);
        reset = 1'b0;
        run_frame(0, 60, FL);
        check("after_reset", 16'({en_act, stage, stage_adv}), 16'({5'b00001, 3'd0, 1'b0}));

`ifdef STAGE_TIMEOUT_EN
        run_frame(0, 60, FL);
        run_frame(0, 60, FL);
        check("to_adv1", 16'({stage, stage_adv}), 16'({3'd1, 1'b1}));
        idle_frames(COOL);
        for (int i = 0; i < 3; i++) run_frame(1, 60, FL);
        idle_frames(COOL);
        check("to_in_st2", 16'({en_act, stage}), 16'({5'b00100, 3'd2}));
        idle_frames(TO - 1);
        check("to_not_yet", 16'({en_act, stage, timeout}), 16'({5'b00100, 3'd2, 1'b0}));
        idle_frames(1);
        check("to_pulse", 16'({en_act, stage, stage_adv, timeout}), 16'({5'b00000, 3'd0, 1'b1, 1'b1}));
        @(negedge clk_25MHz);
        check("to_one_cycle", 16'({timeout, stage_adv}), 16'({1'b0, 1'b0}));
        idle_frames(COOL);
        check("to_back_start", 16'({en_act, stage, stage_adv}), 16'({5'b00001, 3'd0, 1'b0}));
`endif

        // Randomized frames, restarts and flag densities against the model.
        for (int f = 0; f < 250; f++) begin
            int len, p;
            len = $urandom_range(60, 110);
            case ($urandom_range(0, 3))
                0: p = 20;
                1: p = 50;
                2: p = 75;
                default: p = 95;
            endcase
            for (int c = 0; c < len; c++) begin
                @(negedge clk_25MHz);
                for (int b = 0; b < 5; b++) flags[b] = ($urandom_range(0, 99) < p);
                restart    = ($urandom_range(0, 63) == 0);
                frame_tick = (c == len - 1);
            end
        end
        @(negedge clk_25MHz);
        flags = 5'b00000; restart = 1'b0; frame_tick = 1'b0;
        @(negedge clk_25MHz);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
